// File: rtl/tis_pkg.sv
// Shared TIS definitions: word type, saturation bounds and source FSM states.
package tis_pkg;

    typedef logic signed [10:0] tis_word_t;

    localparam tis_word_t TIS_MAX = 11'sd999;
    localparam tis_word_t TIS_MIN = -11'sd999;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        OFFER = 3'd2,
        GAP   = 3'd3,
        FIN   = 3'd4
    } src_state_t;

endpackage

// File: rtl/tis_clamp.sv
// Combinational saturation of a TIS word to [TIS_MIN, TIS_MAX].
module tis_clamp
    import tis_pkg::*;
(
    input  tis_word_t word_i,
    output tis_word_t word_o
);

    // Saturate out-of-range words to the nearest legal bound.
    always_comb begin
        if (word_i > TIS_MAX) begin
            word_o = TIS_MAX;
        end else if (word_i < TIS_MIN) begin
            word_o = TIS_MIN;
        end else begin
            word_o = word_i;
        end
    end

endmodule

// File: rtl/tis_source.sv
// TIS word transmitter: offers values[0..len-1] one at a time on write/out,
// advancing on each wready acknowledge, with one idle cycle between words.
// Optional macro TIS_SOURCE_LOOP_EN: restart from index 0 after the last
// word instead of finishing (run repeats until reset, done never sets).
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | fetch first word into out
// OFFER | write high, waiting for wready
// GAP   | write low, fetch next word
// FIN   | run complete, raise done
module tis_source
    import tis_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int CW    = 8,
    localparam int LW    = $clog2(DEPTH + 1),
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  tis_word_t        values [DEPTH],
    input  logic [LW-1:0]    len,
    input  logic             start,
    input  logic             wready,
    output logic             write,
    output tis_word_t        out,
    output logic [CW-1:0]    count,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_LOAD  = LOAD;
    localparam logic [2:0] S_OFFER = OFFER;
    localparam logic [2:0] S_GAP   = GAP;
    localparam logic [2:0] S_FIN   = FIN;

    logic [2:0]    state_q, state_d;
    tis_word_t     out_q, out_d;
    logic [CW-1:0] count_q, count_d;
    logic [LW-1:0] index_q, index_d;
    logic [LW-1:0] len_q, len_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    tis_word_t     word_raw;
    tis_word_t     word_sat;
    logic [IW-1:0] rd_idx;

    // index never reaches len_q while fetching, so the low bits address the table
    assign rd_idx   = index_q[IW-1:0];
    assign word_raw = values[rd_idx];

    tis_clamp u_clamp (
        .word_i (word_raw),
        .word_o (word_sat)
    );

    // Next-state and datapath updates for the transmit sequence.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        count_d = count_q;
        index_d = index_q;
        len_d   = len_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
                    count_d = '0;
                    done_d  = 1'b0;
                    index_d = '0;
                    busy_d  = 1'b1;
                    state_d = (len == '0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                out_d   = word_sat;
                state_d = S_OFFER;
            end
            S_OFFER: begin
                if (wready) begin
                    if (count_q != '1) begin
                        count_d = count_q + 1'b1;
                    end
                    index_d = index_q + 1'b1;
                    if (index_q + 1'b1 == len_q) begin
`ifdef TIS_SOURCE_LOOP_EN
                        index_d = '0;
                        state_d = S_GAP;
`else
                        state_d = S_FIN;
`endif
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                out_d   = word_sat;
                state_d = S_OFFER;
            end
            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            count_q <= '0;
            index_q <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            count_q <= count_d;
            index_q <= index_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign write = (state_q == S_OFFER);
    assign out   = out_q;
    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_tis_source.sv
// Self-checking bench for tis_source: table vectors, hand sequences and
// randomized runs against a word-list reference model.
module tb_tis_source;
    import tis_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = 8;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          start  = 1'b0;
    logic          wready = 1'b0;
    logic [LW-1:0] len    = '0;
    tis_word_t     vals [DEPTH];
    logic          write, busy, done;
    tis_word_t     out;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    int got_q[$];

    always #5 clk = ~clk;

    tis_source #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .values (vals),
        .len    (len),
        .start  (start),
        .wready (wready),
        .write  (write),
        .out    (out),
        .count  (count),
        .busy   (busy),
        .done   (done)
    );

    typedef struct {
        string nm;
        int    len;
        int    v0, v1, v2;
        int    wait_c;
        int    exp_cnt;
        int    e0, e1, e2;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ref_clamp(input int v);
        if (v > 999) return 999;
        if (v < -999) return -999;
        return v;
    endfunction

    // One complete run: wait_mode >= 0 acks after that many offer cycles,
    // -1 picks a random 0..3 wait per word; spur adds wready while write is low.
    task automatic run_check(input string nm, input int n_len, input int wait_mode, input bit spur);
        int eff, cyc, first_rise, gap, waited, target, exp_cnt;
        bit prev_w, acked, saw_write, finished;
        tis_word_t held;
        eff = (n_len > DEPTH) ? DEPTH : n_len;
        got_q.delete();
        @(negedge clk);
        start = 1'b1;
        len = LW'(n_len);
        wready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; first_rise = -1; gap = 0; waited = 0;
        prev_w = 0; acked = 0; saw_write = 0; finished = 0;
        held = '0;
        target = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
        while (!finished) begin
            cyc++;
            exp_cnt = (got_q.size() > 255) ? 255 : got_q.size();
            chk({nm, " count"}, int'(count), exp_cnt);
            if (cyc == 1) chk({nm, " busy after start"}, int'(busy), 1);
            if (acked) chk({nm, " write low after accept"}, int'(write), 0);
            if (prev_w && !write && !acked) chk({nm, " write dropped unacked"}, int'(write), 1);
            if (write) begin
                if (!prev_w) begin
                    if (first_rise < 0) begin
                        first_rise = cyc;
                        chk({nm, " first write latency"}, cyc, 2);
                    end else begin
                        chk({nm, " gap length"}, gap, 1);
                    end
                    held = out;
                    waited = 0;
                    gap = 0;
                end else begin
                    chk({nm, " out held"}, int'(out), int'(held));
                end
                saw_write = 1;
            end else if (saw_write) begin
                gap++;
            end
            if (done) finished = 1;
            acked = 0;
            wready = 1'b0;
            if (!finished) begin
                if (write) begin
                    if (waited >= target) begin
                        wready = 1'b1;
                        acked = 1;
                        got_q.push_back(int'(out));
                        target = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
                    end else begin
                        waited++;
                    end
                end else if (spur && ($urandom_range(0, 1) == 1)) begin
                    wready = 1'b1;
                end
                if (cyc > 3000) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s timeout: got no done after %0d cycles, required done", nm, cyc);
                    finished = 1;
                end
                prev_w = write;
                @(negedge clk);
            end
        end
        wready = 1'b0;
        chk({nm, " words accepted"}, got_q.size(), eff);
        chk({nm, " final count"}, int'(count), (eff > 255) ? 255 : eff);
        chk({nm, " busy at end"}, int'(busy), 0);
        chk({nm, " write at end"}, int'(write), 0);
        chk({nm, " done at end"}, int'(done), 1);
        if (eff == 0) chk({nm, " write never high"}, int'(saw_write), 0);
        for (int i = 0; i < got_q.size() && i < eff; i++)
            chk($sformatf("%s word%0d", nm, i), got_q[i], ref_clamp(int'(vals[i])));
    endtask

    initial begin
        vec_t vt[$];
        int   cnt_before;
        bit   seen;

        for (int i = 0; i < DEPTH; i++) vals[i] = '0;

        // reset values
        #12;
        chk("reset write", int'(write), 0);
        chk("reset out", int'(out), 0);
        chk("reset count", int'(count), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        @(negedge clk);
        rst = 1'b1;

`ifdef TIS_SOURCE_LOOP_EN
        vals[0] = 11'sd1;
        vals[1] = 11'sd2;
        got_q.delete();
        @(negedge clk);
        start = 1'b1;
        len = LW'(2);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && got_q.size() < 5; c++) begin
            wready = 1'b0;
            if (write) begin
                wready = 1'b1;
                got_q.push_back(int'(out));
            end
            @(negedge clk);
        end
        wready = 1'b0;
        chk("loop words", got_q.size(), 5);
        for (int i = 0; i < got_q.size(); i++)
            chk($sformatf("loop word%0d", i), got_q[i], (i % 2 == 0) ? 1 : 2);
        chk("loop done stays low", int'(done), 0);
        chk("loop busy", int'(busy), 1);
`else
        vt.push_back('{"basic",   3,  5,    -7,    999,  1,  3,  5,   -7,   999});
        vt.push_back('{"backpr",  2,  42,   -3,    0,    20, 2,  42,  -3,   0});
        vt.push_back('{"clamp",   2,  1023, -1024, 0,    0,  2,  999, -999, 0});
        vt.push_back('{"clamp2",  3,  1000, -1000, -999, 2,  3,  999, -999, -999});
        vt.push_back('{"empty",   0,  7,    8,     9,    0,  0,  0,   0,    0});
        vt.push_back('{"overlen", 20, 1,    2,     3,    0,  16, 1,   2,    3});

        foreach (vt[k]) begin
            for (int i = 3; i < DEPTH; i++) vals[i] = tis_word_t'(i * 130 - 1000);
            vals[0] = tis_word_t'(vt[k].v0);
            vals[1] = tis_word_t'(vt[k].v1);
            vals[2] = tis_word_t'(vt[k].v2);
            run_check(vt[k].nm, vt[k].len, vt[k].wait_c, 1'b0);
            chk({vt[k].nm, " table count"}, int'(count), vt[k].exp_cnt);
            if (vt[k].exp_cnt > 0 && got_q.size() > 0) chk({vt[k].nm, " table w0"}, got_q[0], vt[k].e0);
            if (vt[k].exp_cnt > 1 && got_q.size() > 1) chk({vt[k].nm, " table w1"}, got_q[1], vt[k].e1);
            if (vt[k].exp_cnt > 2 && got_q.size() > 2) chk({vt[k].nm, " table w2"}, got_q[2], vt[k].e2);
        end

        // spurious wready while idle
        cnt_before = got_q.size();
        @(negedge clk);
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        @(negedge clk);
        chk("spurious idle count", int'(count), cnt_before);
        chk("spurious idle write", int'(write), 0);

        // start while busy is ignored: second start mid-run must not restart
        vals[0] = 11'sd10; vals[1] = 11'sd20;
        @(negedge clk);
        start = 1'b1; len = LW'(2);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start while busy out", int'(out), 20);
        chk("start while busy count", int'(count), 1);
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        @(negedge clk);
        chk("start while busy done", int'(done), 1);

        // reset in the middle of a run
        vals[0] = 11'sd11; vals[1] = 11'sd22; vals[2] = 11'sd33;
        @(negedge clk);
        start = 1'b1; len = LW'(3);
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (write) seen = 1;
            else @(negedge clk);
        end
        chk("rst seq first offer", int'(write), 1);
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        @(negedge clk);
        chk("rst seq offer count", int'(count), 1);
        chk("rst seq offer write", int'(write), 1);
        chk("rst seq offer out", int'(out), 22);
        rst = 1'b0;
        #1;
        chk("mid rst write", int'(write), 0);
        chk("mid rst out", int'(out), 0);
        chk("mid rst count", int'(count), 0);
        chk("mid rst busy", int'(busy), 0);
        chk("mid rst done", int'(done), 0);
        @(negedge clk);
        chk("held rst write", int'(write), 0);
        rst = 1'b1;
        run_check("after rst", 3, 0, 1'b0);
        if (got_q.size() > 0) chk("after rst first word", got_q[0], 11);

        // randomized runs
        for (int r = 0; r < 40; r++) begin
            int rl;
            for (int i = 0; i < DEPTH; i++) vals[i] = tis_word_t'($urandom_range(0, 2047));
            rl = int'($urandom_range(0, 20));
            run_check($sformatf("rand%0d", r), rl, -1, 1'b1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
